// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Purpose  : Nominal 640x480 VGA frame constants and capture FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int VGA_H_TOTAL  = 800;
    localparam int VGA_V_TOTAL  = 525;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } capture_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_line_meter.sv
`default_nettype none
// ============================================================================
// Module   : vga_line_meter
// Purpose  : HS edge detect, pixel/active-pixel counters and per-line check.
// Revision : 1.0 - initial release
// ============================================================================
module vga_line_meter
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL  = VGA_H_TOTAL,
    parameter int H_ACTIVE = VGA_H_ACTIVE
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       pix_en,
    input  logic       hs,
    input  logic       blank,
    output logic       hs_fall,
    output logic [9:0] ax,
    output logic       line_bad
);

    localparam logic [9:0] c_cnt_max = 10'h3FF;

    logic       r_hs_prev;
    logic [9:0] r_hcnt;
    logic [9:0] r_ax;

    assign hs_fall  = pix_en & r_hs_prev & ~hs;
    // Counters still hold the values of the line that ends on this sample.
    assign line_bad = hs_fall &
                      ((({1'b0, r_hcnt} + 11'd1) != 11'(H_TOTAL)) |
                       ((r_ax != 10'd0) && (r_ax != 10'(H_ACTIVE))));
    assign ax       = r_ax;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_hs_prev <= 1'b1;
            r_hcnt    <= 10'd0;
            r_ax      <= 10'd0;
        end else if (pix_en) begin
            r_hs_prev <= hs;
            if (hs_fall) begin
                r_hcnt <= 10'd0;
                r_ax   <= 10'd0;
            end else begin
                if (r_hcnt != c_cnt_max)
                    r_hcnt <= r_hcnt + 10'd1;
                if (blank && (r_ax != c_cnt_max))
                    r_ax <= r_ax + 10'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_frame_capture.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_capture
// Purpose  : VGA sink - timing lock, frame checks, downsampled framebuffer writes.
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_capture
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int SCALE_SHIFT = 1,
    parameter int COLOR_BITS  = 4,
    parameter int X_W         = 9,
    parameter int Y_W         = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    pix_en,
    input  logic                    VGA_HS,
    input  logic                    VGA_VS,
    input  logic                    VGA_BLANK,
    input  logic [9:0]              VGA_R,
    input  logic [9:0]              VGA_G,
    input  logic [9:0]              VGA_B,
    output logic                    wr_en,
    output logic [X_W-1:0]          wr_x,
    output logic [Y_W-1:0]          wr_y,
    output logic [3*COLOR_BITS-1:0] wr_data,
    output logic                    frame_done,
    output logic                    locked,
    output logic                    sync_err
);

    localparam logic [9:0] c_sub_mask = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [9:0] c_lcnt_max = 10'h3FF;
    localparam logic [8:0] c_ay_max   = 9'h1FF;

    logic           w_hs_fall;
    logic           w_line_bad;
    logic [9:0]     w_ax;
    logic           w_vs_fall;
    logic           w_frame_bad;
    logic           w_overrun;
    logic           w_write;
    logic           w_unused;

    logic           r_vs_prev;
    logic [9:0]     r_lcnt;
    logic [8:0]     r_ay;
    capture_state_t r_state;
    logic           r_bad;
    logic           r_locked;
    logic           r_sync_err;
    logic           r_frame_done;
    logic                    r_wr_en;
    logic [X_W-1:0]          r_wr_x;
    logic [Y_W-1:0]          r_wr_y;
    logic [3*COLOR_BITS-1:0] r_wr_data;

    vga_line_meter #(
        .H_TOTAL  (H_TOTAL),
        .H_ACTIVE (H_ACTIVE)
    ) u_line_meter (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .pix_en   (pix_en),
        .hs       (VGA_HS),
        .blank    (VGA_BLANK),
        .hs_fall  (w_hs_fall),
        .ax       (w_ax),
        .line_bad (w_line_bad)
    );

    assign w_vs_fall   = pix_en & r_vs_prev & ~VGA_VS;
    assign w_frame_bad = w_vs_fall &
                         ((({1'b0, r_lcnt} + 11'd1) != 11'(V_TOTAL)) |
                          (r_ay != 9'(V_ACTIVE)));
    assign w_overrun   = pix_en & VGA_BLANK &
                         ((w_ax >= 10'(H_ACTIVE)) | (r_ay >= 9'(V_ACTIVE)));
    assign w_write     = pix_en & VGA_BLANK & ~w_overrun & (r_state == LOCKED) &
                         ((w_ax & c_sub_mask) == 10'd0) &
                         ((r_ay & c_sub_mask[8:0]) == 9'd0);
    assign w_unused    = ^{VGA_R[9-COLOR_BITS:0], VGA_G[9-COLOR_BITS:0],
                           VGA_B[9-COLOR_BITS:0]};

    // A VS fall also clears on a coincident HS fall: that line is line 0.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_vs_prev <= 1'b1;
            r_lcnt    <= 10'd0;
            r_ay      <= 9'd0;
        end else if (pix_en) begin
            r_vs_prev <= VGA_VS;
            if (w_vs_fall) begin
                r_lcnt <= 10'd0;
                r_ay   <= 9'd0;
            end else if (w_hs_fall) begin
                if (r_lcnt != c_lcnt_max)
                    r_lcnt <= r_lcnt + 10'd1;
                if ((w_ax != 10'd0) && (r_ay != c_ay_max))
                    r_ay <= r_ay + 9'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state      <= SEARCH;
            r_bad        <= 1'b0;
            r_locked     <= 1'b0;
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync_err   <= 1'b0;
            r_frame_done <= 1'b0;
            if (pix_en) begin
                case (r_state)
                    SEARCH: begin
                        if (w_vs_fall) begin
                            r_state <= ALIGN;
                            r_bad   <= 1'b0;
                        end
                    end
                    ALIGN: begin
                        if (w_vs_fall) begin
                            r_bad <= 1'b0;
                            if (!(r_bad | w_line_bad | w_frame_bad)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else if (w_line_bad | w_overrun) begin
                            r_bad <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_vs_fall && !w_frame_bad)
                            r_frame_done <= 1'b1;
                        if (w_line_bad | w_frame_bad | w_overrun) begin
                            r_state    <= ALIGN;
                            r_locked   <= 1'b0;
                            r_sync_err <= 1'b1;
                            // The frame in progress is tainted unless a new one starts here.
                            r_bad      <= ~w_vs_fall;
                        end
                    end
                    default: begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_wr_en   <= 1'b0;
            r_wr_x    <= '0;
            r_wr_y    <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_write;
            if (w_write) begin
                r_wr_x    <= X_W'(w_ax >> SCALE_SHIFT);
                r_wr_y    <= Y_W'(r_ay >> SCALE_SHIFT);
                r_wr_data <= {VGA_R[9 -: COLOR_BITS], VGA_G[9 -: COLOR_BITS],
                              VGA_B[9 -: COLOR_BITS]};
            end
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_x       = r_wr_x;
    assign wr_y       = r_wr_y;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign sync_err   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_vga_frame_capture
// Purpose  : Self-checking bench for vga_frame_capture on a reduced frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_capture;

    localparam int HT = 40, HA = 16, VT = 30, VA = 12;
    localparam int HSYNC = 4, HBP = 4, VSYNC = 2, VBP = 3;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       pix_en = 1'b0;
    logic       VGA_HS = 1'b1, VGA_VS = 1'b1, VGA_BLANK = 1'b0;
    logic [9:0] VGA_R = '0, VGA_G = '0, VGA_B = '0;
    logic       wr_en, frame_done, locked, sync_err;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic [11:0] wr_data;

    always #10 CLOCK_50 = ~CLOCK_50;

    vga_frame_capture #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .SCALE_SHIFT(1), .COLOR_BITS(4), .X_W(9), .Y_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .pix_en(pix_en),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .frame_done(frame_done), .locked(locked), .sync_err(sync_err)
    );

    int n_chk = 0, n_err = 0;
    bit chk_on = 1'b0;
    // Expected outputs for the next negedge
    logic e_wr = 0, e_se = 0, e_fd = 0, e_lk = 0;
    logic [8:0] e_x = 0;
    logic [7:0] e_y = 0;
    logic [11:0] e_d = 0;
    // Frame-level lock model
    bit m_locked = 0, m_armed = 0, m_clean = 0;
    // Observed output history
    int obs_wr = 0, obs_se = 0, obs_fd = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1, last_d = -1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLOCK_50) begin
        if (chk_on) begin
            check("wr_en", int'(wr_en), int'(e_wr));
            if (e_wr && wr_en) begin
                check("wr_x", int'(wr_x), int'(e_x));
                check("wr_y", int'(wr_y), int'(e_y));
                check("wr_data", int'(wr_data), int'(e_d));
            end
            check("sync_err", int'(sync_err), int'(e_se));
            check("frame_done", int'(frame_done), int'(e_fd));
            check("locked", int'(locked), int'(e_lk));
            if (wr_en) begin
                if (obs_wr == 0) begin
                    first_x = int'(wr_x);
                    first_y = int'(wr_y);
                end
                last_x = int'(wr_x);
                last_y = int'(wr_y);
                last_d = int'(wr_data);
                obs_wr++;
            end
            obs_se += int'(sync_err);
            obs_fd += int'(frame_done);
        end
    end

    // One pixel strobe followed by one idle cycle; updates the model afterwards.
    task automatic pix(input bit hs, input bit vs, input bit bl, input int x, input int y,
                       input bit vsf, input bit flt);
        logic [9:0] r, g, b;
        @(posedge CLOCK_50); #1;
        e_wr = 0; e_se = 0; e_fd = 0;
        r = {x[3:0], 6'($urandom)};
        g = {y[3:0], 6'($urandom)};
        b = {4'(x ^ y), 6'($urandom)};
        VGA_HS = hs; VGA_VS = vs; VGA_BLANK = bl;
        VGA_R = r; VGA_G = g; VGA_B = b;
        pix_en = 1'b1;
        @(posedge CLOCK_50); #1;
        pix_en = 1'b0;
        if (m_locked && bl && !flt && (x % 2 == 0) && (y % 2 == 0)) begin
            e_wr = 1;
            e_x = 9'(x / 2);
            e_y = 8'(y / 2);
            e_d = {r[9:6], g[9:6], b[9:6]};
        end
        if (flt) begin
            if (m_locked) e_se = 1;
            m_locked = 0;
            m_clean = 0;
        end
        if (vsf) begin
            if (m_locked) e_fd = 1;
            else if (m_armed && m_clean) m_locked = 1;
            m_armed = 1;
            m_clean = 1;
        end
        e_lk = m_locked;
    endtask

    task automatic do_reset();
        check("pre_reset_locked", int'(locked), 1);
        #5;
        resetn = 1'b0;
        e_wr = 0; e_se = 0; e_fd = 0; e_lk = 0;
        m_locked = 0; m_armed = 0; m_clean = 0;
        #2;
        check("async_wr_en", int'(wr_en), 0);
        check("async_locked", int'(locked), 0);
        check("async_wr_x", int'(wr_x), 0);
        check("async_wr_data", int'(wr_data), 0);
        repeat (3) @(posedge CLOCK_50);
        #1 resetn = 1'b1;
    endtask

    task automatic idle_burst();
        repeat (100) begin
            @(posedge CLOCK_50); #1;
            e_wr = 0; e_se = 0; e_fd = 0;
            VGA_HS = 1'($urandom); VGA_VS = 1'($urandom); VGA_BLANK = 1'($urandom);
            VGA_R = 10'($urandom); VGA_G = 10'($urandom); VGA_B = 10'($urandom);
        end
    endtask

    task automatic send_frame(input int short_ln, input int long_ln, input int rst_ln,
                              input int rst_px, input int idle_ln, input int idle_px);
        int npx, last_bl;
        bit act, bl, flt;
        for (int ln = 0; ln < VT; ln++) begin
            npx = (ln == short_ln) ? HT - 1 : HT;
            last_bl = (ln == long_ln) ? HSYNC + HBP + HA : HSYNC + HBP + HA - 1;
            act = (ln >= VSYNC + VBP) && (ln < VSYNC + VBP + VA);
            for (int px = 0; px < npx; px++) begin
                bl = act && (px >= HSYNC + HBP) && (px <= last_bl);
                flt = (short_ln >= 0 && ln == short_ln + 1 && px == 0) ||
                      (long_ln >= 0 && ln == long_ln && px == last_bl) ||
                      (long_ln >= 0 && ln == long_ln + 1 && px == 0);
                pix(px >= HSYNC, ln >= VSYNC, bl, px - HSYNC - HBP, ln - VSYNC - VBP,
                    (ln == 0) && (px == 0), flt);
                if (ln == rst_ln && px == rst_px) do_reset();
                if (ln == idle_ln && px == idle_px) idle_burst();
            end
        end
    endtask

    int w0, se0;

    initial begin
        repeat (3) @(posedge CLOCK_50); #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_sync_err", int'(sync_err), 0);
        check("rst_frame_done", int'(frame_done), 0);
        resetn = 1'b1;
        chk_on = 1'b1;

        // Nominal frames
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f0_locked", int'(locked), 0);
        check("f0_writes", obs_wr - w0, 0);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f1_locked", int'(locked), 1);
        check("f1_writes", obs_wr - w0, 48);
        check("f1_first_x", first_x, 0);
        check("f1_first_y", first_y, 0);
        check("f1_last_x", last_x, 7);
        check("f1_last_y", last_y, 5);
        check("f1_last_data", last_d, 'hEA4);
        check("f1_frame_done", obs_fd, 0);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f2_writes", obs_wr - w0, 48);
        check("f2_frame_done", obs_fd, 1);
        check("f2_sync_err", obs_se, 0);

        // Short line 10 while locked
        w0 = obs_wr; send_frame(10, -1, -1, -1, -1, -1);
        check("f3_sync_err", obs_se, 1);
        check("f3_locked", int'(locked), 0);
        check("f3_writes", obs_wr - w0, 24);
        check("f3_frame_done", obs_fd, 2);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f4_writes", obs_wr - w0, 0);
        check("f4_locked", int'(locked), 0);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f5_locked", int'(locked), 1);
        check("f5_writes", obs_wr - w0, 48);

        // BLANK one pixel too long on line 7
        w0 = obs_wr; send_frame(-1, 7, -1, -1, -1, -1);
        check("f6_writes", obs_wr - w0, 16);
        check("f6_sync_err", obs_se, 2);
        check("f6_locked", int'(locked), 0);
        check("f6_frame_done", obs_fd, 3);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f7_writes", obs_wr - w0, 0);

        // Asynchronous reset mid-line
        w0 = obs_wr; send_frame(-1, -1, 9, 15, -1, -1);
        check("f8_writes", obs_wr - w0, 20);
        check("f8_locked", int'(locked), 0);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f9_writes", obs_wr - w0, 0);
        check("f9_locked", int'(locked), 0);

        // pix_en held low mid-line
        w0 = obs_wr; se0 = obs_se; send_frame(-1, -1, -1, -1, 7, 12);
        check("f10_writes", obs_wr - w0, 48);
        check("f10_locked", int'(locked), 1);
        check("f10_sync_err", obs_se - se0, 0);
        w0 = obs_wr; send_frame(-1, -1, -1, -1, -1, -1);
        check("f11_writes", obs_wr - w0, 48);
        check("f11_frame_done", obs_fd, 4);
        check("f11_sync_err", obs_se, 2);

        @(posedge CLOCK_50); #1;
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
